module_bin_to_bcd_seq: RTL
==========================

MODULE_BIN_TO_BCD_SEQ -- requirements
Module: module_bin_to_bcd_seq

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the binary input width (legal range 4..32).
REQ-002 Parameter DIGITS, default 5, SHALL set the BCD output digit count (legal range 1..10).
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start_i  input  1  SHALL request a conversion; sampled only in IDLE.
REQ-006 signed_i  input  1  SHALL select two's-complement interpretation of bin_i; sampled with start_i.
REQ-007 bin_i  input  WIDTH  SHALL be the binary operand; sampled with start_i.
REQ-008 bcd_o  output  4*DIGITS  SHALL be packed BCD magnitude, digit 0 (units) in bits [3:0].
REQ-009 sign_o  output  1  SHALL be 1 when the accepted operand was signed and negative.
REQ-010 ovf_o  output  1  SHALL be 1 when the magnitude exceeded 10^DIGITS-1.
REQ-011 busy_o  output  1  SHALL be 1 while a conversion is in progress (SHIFT state).
REQ-012 done_o  output  1  SHALL pulse high for exactly one cycle when results update.

Function
REQ-013 FSM SHALL have states IDLE, SHIFT, DONE; reset state IDLE.
REQ-014 IDLE: start_i=1 at a rising edge SHALL capture the operand, clear the shift counter, clear the BCD working register and sticky overflow, and move to SHIFT.
REQ-015 Operand capture: if signed_i=1 and bin_i[WIDTH-1]=1, the shift register SHALL load the two's-complement negation (WIDTH-bit unsigned; -2^(WIDTH-1) yields magnitude 2^(WIDTH-1)) and latch sign=1; otherwise it SHALL load bin_i and latch sign=0.
REQ-016 SHIFT: each cycle SHALL add 3 to every working digit >=5, then shift {BCD, binary} left one bit, MSB of the binary register entering BCD bit 0 (double-dabble).
REQ-017 SHIFT SHALL last exactly WIDTH cycles, then move to DONE.
REQ-018 Any 1 shifted out of the top BCD digit SHALL set the sticky overflow flag; bcd_o then holds magnitude mod 10^DIGITS.
REQ-019 DONE: bcd_o, sign_o, ovf_o SHALL load from working state; done_o=1 for this one cycle; next state IDLE.
REQ-020 Latency: done_o SHALL assert WIDTH+1 cycles after the edge that accepted start_i; maximum throughput one conversion per WIDTH+2 cycles.
REQ-021 start_i in SHIFT or DONE SHALL be ignored (no queueing); operand changes during SHIFT SHALL have no effect.
REQ-022 bcd_o, sign_o, ovf_o SHALL hold their last values outside DONE-load cycles.
REQ-023 busy_o SHALL be 1 exactly in SHIFT; busy_o and done_o SHALL never be high together.
REQ-024 With signed_i=0, bin_i SHALL be treated as unsigned and sign_o SHALL be 0.

Reset
REQ-025 rst_i=0 SHALL immediately force IDLE and clear bcd_o, sign_o, ovf_o, busy_o, done_o and all working registers to 0.
REQ-026 Reset during SHIFT SHALL abort the conversion with no done_o pulse; first start_i after rst_i rises SHALL convert normally.

Verification (WIDTH=16, DIGITS=5 unless stated)
REQ-027 bin_i=0, signed_i=0, start pulse -> done_o at +17 cycles, bcd_o=0x00000, sign_o=0, ovf_o=0.
REQ-028 bin_i=0xFFFF, signed_i=0 -> bcd_o=0x65535, sign_o=0, ovf_o=0; same with signed_i=1 -> bcd_o=0x00001, sign_o=1.
REQ-029 bin_i=0x8000, signed_i=1 -> bcd_o=0x32768, sign_o=1, ovf_o=0.
REQ-030 DIGITS=4, bin_i=12345 unsigned -> bcd_o=0x2345, ovf_o=1; next conversion of 9999 -> ovf_o=0.
REQ-031 start_i held high continuously with bin_i=42 -> busy_o high 16 cycles, done_o single-cycle pulses every 18 cycles, bcd_o=0x00042; bin_i changed to 7 mid-SHIFT -> current result still 0x00042.
REQ-032 rst_i low at SHIFT cycle 8 -> all outputs 0 immediately, no done_o; after release, bin_i=1000 -> bcd_o=0x01000.

Source files
------------

// File: rtl/module_bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one bit per clock.
// Optional two's-complement input: the magnitude is converted and the sign
// is reported separately. Overflow is sticky across the conversion.

// Per-digit double-dabble adjust: add 3 to any digit >= 5 before the shift.
module bin_to_bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module module_bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                signed_i,
    input  logic [WIDTH-1:0]    bin_i,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                sign_o,
    output logic                ovf_o,
    output logic                busy_o,
    output logic                done_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Operand as captured: sign flag plus unsigned magnitude
    typedef struct packed {
        logic             sign;
        logic [WIDTH-1:0] mag;
    } operand_t;

    state_t                 state, state_nxt;
    operand_t               opnd;
    logic [WIDTH-1:0]       bin_q, bin_nxt;
    logic [DIGITS-1:0][3:0] bcd_q, bcd_adj, bcd_nxt;
    logic                   sign_q, ovf_q;
    logic                   carry;
    logic [CW-1:0]          cnt;
    logic                   last_shift;
    logic                   accept;
    logic                   load_res;

    // Operand decode: negative signed inputs load their magnitude.
    // The most negative value negates to itself, which read as unsigned
    // is exactly its magnitude 2^(WIDTH-1).
    always_comb begin
        opnd.sign = signed_i & bin_i[WIDTH-1];
        opnd.mag  = opnd.sign ? -bin_i : bin_i;
    end

    // One adjust unit per BCD digit
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bin_to_bcd_digit_adj u_adj (
            .d (bcd_q[g]),
            .q (bcd_adj[g])
        );
    end

    // Shift {adjusted BCD, binary} left; the bit leaving the top digit is overflow
    assign {carry, bcd_nxt, bin_nxt} = {bcd_adj, bin_q, 1'b0};

    assign last_shift = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)    state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // FSM decoded controls
    always_comb begin
        busy_o   = (state == SHIFT);
        load_res = (state == DONE);
        accept   = (state == IDLE) && start_i;
    end

    // Working registers: capture on accept, one double-dabble step per SHIFT cycle
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            sign_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            bin_q  <= opnd.mag;
            sign_q <= opnd.sign;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
        end else if (busy_o) begin
            bin_q  <= bin_nxt;
            bcd_q  <= bcd_nxt;
            ovf_q  <= ovf_q | carry;
            cnt    <= cnt + 1'b1;
        end
    end

    // Result registers: load in DONE, hold otherwise; done_o marks the update
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            bcd_o  <= '0;
            sign_o <= 1'b0;
            ovf_o  <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= load_res;
            if (load_res) begin
                bcd_o  <= bcd_q;
                sign_o <= sign_q;
                ovf_o  <= ovf_q;
            end
        end
    end
endmodule
